// File: rtl/leaf_stream_buffer.sv
// -----------------------------------------------------------------------------
// leaf_stream_buffer
//
// Multi-channel elastic buffer placed between a leaf_interface user-side bus
// and a user kernel's AXI-stream ports. One instance is used per direction.
// Every channel has its own FIFO of 2**DEPTH_BITS entries, its own flush, and
// shares a common ap_start gate on the output side.
//
// Parameters
//   PAYLOAD_BITS  data width per channel
//   NUM_CH        number of independent channels; channel k uses
//                 bits [k*PAYLOAD_BITS +: PAYLOAD_BITS]
//   DEPTH_BITS    log2 of per-channel depth (minimum 1)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   ap_start    when low, no channel presents data (m_vld forced low)
//   flush       per-channel synchronous clear of FIFO contents
//   s_data      upstream data,  NUM_CH*PAYLOAD_BITS
//   s_vld       upstream valid, NUM_CH
//   s_ack       ready to upstream, NUM_CH
//   m_data      downstream data (FIFO head), NUM_CH*PAYLOAD_BITS
//   m_vld       downstream valid, NUM_CH
//   m_ack       ready from downstream, NUM_CH
//   occupancy   per-channel entry count, NUM_CH*(DEPTH_BITS+1)
//   stat_words  (only with LEAF_STREAM_STATS_EN defined) per-channel 32-bit
//               pop counter, cleared by reset only
//
// Handshake: on each side a transfer happens in a cycle where valid and
// ready are both high at the rising edge. s_ack depends only on local state
// (reset, flush, count), never on m_ack, so there is no combinational path
// from the downstream ready to the upstream ready. A pushed word is visible
// at the output one cycle later; there is no same-cycle pass-through.
//
// Optional feature macro: LEAF_STREAM_STATS_EN
// -----------------------------------------------------------------------------
module leaf_stream_buffer #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_CH       = 2,
  parameter int DEPTH_BITS   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ap_start,
  input  logic [NUM_CH-1:0]                flush,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0]   s_data,
  input  logic [NUM_CH-1:0]                s_vld,
  output logic [NUM_CH-1:0]                s_ack,
  output logic [NUM_CH*PAYLOAD_BITS-1:0]   m_data,
  output logic [NUM_CH-1:0]                m_vld,
  input  logic [NUM_CH-1:0]                m_ack,
`ifdef LEAF_STREAM_STATS_EN
  output logic [NUM_CH*32-1:0]             stat_words,
`endif
  output logic [NUM_CH*(DEPTH_BITS+1)-1:0] occupancy
);

  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS+1)'(DEPTH);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]     count_q, count_d;
    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic                    push;
    logic                    pop;

    // Flush and reset pull both handshakes low, so a flushed or reset
    // channel can never see a push or pop in the same cycle.
    assign s_ack[k] = !reset && !flush[k] && (count_q != FULL_CNT);
    assign m_vld[k] = !reset && ap_start && !flush[k] && (count_q != '0);

    assign push = s_vld[k] && s_ack[k];
    assign pop  = m_vld[k] && m_ack[k];

    assign m_data[k*PAYLOAD_BITS +: PAYLOAD_BITS]     = mem_q[rd_ptr_q];
    assign occupancy[k*(DEPTH_BITS+1) +: DEPTH_BITS+1] = count_q;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are exactly DEPTH_BITS wide, so wrap-around is free.
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (DEPTH_BITS+1)'(1);
        2'b01:   count_d = count_q - (DEPTH_BITS+1)'(1);
        default: count_d = count_q;
      endcase
      if (flush[k]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage carries no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

`ifdef LEAF_STREAM_STATS_EN
    logic [31:0] stat_q, stat_d;

    // Counts completed pops; wraps naturally at 2**32 and survives flush.
    always_comb begin
      stat_d = stat_q;
      if (pop) stat_d = stat_q + 32'd1;
    end

    always_ff @(posedge clk) begin
      if (reset) stat_q <= '0;
      else       stat_q <= stat_d;
    end

    assign stat_words[k*32 +: 32] = stat_q;
`endif
  end

endmodule

// File: tb/tb_leaf_stream_buffer.sv
module tb_leaf_stream_buffer;
  localparam int PB    = 32;
  localparam int NC    = 2;
  localparam int DB    = 2;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               ap_start;
  logic [NC-1:0]      flush;
  logic [NC*PB-1:0]   s_data;
  logic [NC-1:0]      s_vld;
  logic [NC-1:0]      s_ack;
  logic [NC*PB-1:0]   m_data;
  logic [NC-1:0]      m_vld;
  logic [NC-1:0]      m_ack;
  logic [NC*(DB+1)-1:0] occupancy;
`ifdef LEAF_STREAM_STATS_EN
  logic [NC*32-1:0]   stat_words;
`endif

  leaf_stream_buffer #(.PAYLOAD_BITS(PB), .NUM_CH(NC), .DEPTH_BITS(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .ap_start   (ap_start),
    .flush      (flush),
    .s_data     (s_data),
    .s_vld      (s_vld),
    .s_ack      (s_ack),
    .m_data     (m_data),
    .m_vld      (m_vld),
    .m_ack      (m_ack),
`ifdef LEAF_STREAM_STATS_EN
    .stat_words (stat_words),
`endif
    .occupancy  (occupancy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;

  logic [PB-1:0] exp_q0[$];
  logic [PB-1:0] exp_q1[$];
  logic [31:0]   exp_stat [NC];
  logic [NC-1:0] exp_push;
  logic [NC-1:0] exp_pop;

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [PB-1:0] qhead(input int k);
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at the falling edge: compares every output with the model and
  // records which transfers the model expects at the coming rising edge.
  task automatic sample_model();
    for (int k = 0; k < NC; k++) begin
      int  sz;
      logic e_sack, e_mvld;
      sz     = qsize(k);
      e_sack = !reset && !flush[k] && (sz < DEPTH);
      e_mvld = !reset && ap_start && !flush[k] && (sz > 0);
      check($sformatf("s_ack[%0d]", k), 64'(s_ack[k]), 64'(e_sack));
      check($sformatf("m_vld[%0d]", k), 64'(m_vld[k]), 64'(e_mvld));
      check($sformatf("occupancy[%0d]", k), 64'(occupancy[k*(DB+1) +: DB+1]), 64'(sz));
      if (e_mvld)
        check($sformatf("m_data[%0d]", k), 64'(m_data[k*PB +: PB]), 64'(qhead(k)));
`ifdef LEAF_STREAM_STATS_EN
      check($sformatf("stat_words[%0d]", k), 64'(stat_words[k*32 +: 32]), 64'(exp_stat[k]));
`endif
      exp_push[k] = s_vld[k] && e_sack;
      exp_pop[k]  = m_ack[k] && e_mvld;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < NC; k++) begin
      if (reset) begin
        if (k == 0) exp_q0.delete(); else exp_q1.delete();
        exp_stat[k] = '0;
      end else if (flush[k]) begin
        if (k == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        if (exp_pop[k]) begin
          if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
          exp_stat[k] = exp_stat[k] + 32'd1;
        end
        if (exp_push[k]) begin
          if (k == 0) exp_q0.push_back(s_data[0 +: PB]);
          else        exp_q1.push_back(s_data[PB +: PB]);
        end
      end
    end
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample_model();
    advance();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; ap_start = 1'b1; flush = '0; s_vld = '0; m_ack = '0; s_data = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        rst;
    logic        ap;
    logic [1:0]  fl;
    logic [1:0]  sv;
    logic [31:0] sd0;
    logic [1:0]  ma;
    logic [1:0]  e_sack;
    logic [1:0]  e_mvld;
    logic [2:0]  e_occ0;
    logic [2:0]  e_occ1;
    logic [31:0] e_d0;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Reset/idle, then fill channel 0 to full and drain it in order.
    vecs[0]  = '{1'b1, 1'b1, 2'b00, 2'b00, 32'h00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 2'b00, 2'b00, 32'h00, 2'b00, 2'b11, 2'b00, 3'd0, 3'd0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 2'b01, 32'hA0, 2'b00, 2'b11, 2'b00, 3'd0, 3'd0, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 2'b01, 32'hA1, 2'b00, 2'b11, 2'b01, 3'd1, 3'd0, 32'hA0};
    vecs[4]  = '{1'b0, 1'b1, 2'b00, 2'b01, 32'hA2, 2'b00, 2'b11, 2'b01, 3'd2, 3'd0, 32'hA0};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 2'b01, 32'hA3, 2'b00, 2'b11, 2'b01, 3'd3, 3'd0, 32'hA0};
    vecs[6]  = '{1'b0, 1'b1, 2'b00, 2'b01, 32'hA4, 2'b00, 2'b10, 2'b01, 3'd4, 3'd0, 32'hA0};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 2'b00, 32'h00, 2'b01, 2'b10, 2'b01, 3'd4, 3'd0, 32'hA0};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 2'b00, 32'h00, 2'b01, 2'b11, 2'b01, 3'd3, 3'd0, 32'hA1};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, 2'b00, 32'h00, 2'b01, 2'b11, 2'b01, 3'd2, 3'd0, 32'hA2};
    vecs[10] = '{1'b0, 1'b1, 2'b00, 2'b00, 32'h00, 2'b01, 2'b11, 2'b01, 3'd1, 3'd0, 32'hA3};
    vecs[11] = '{1'b0, 1'b1, 2'b00, 2'b00, 32'h00, 2'b00, 2'b11, 2'b00, 3'd0, 3'd0, 32'h00};

    for (int k = 0; k < NC; k++) exp_stat[k] = '0;
    exp_push = '0;
    exp_pop  = '0;

    // Initial reset edge, unchecked: state is unknown beforehand.
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // ---- table-driven section ----
    for (int i = 0; i < 12; i++) begin
      reset    = vecs[i].rst;
      ap_start = vecs[i].ap;
      flush    = vecs[i].fl;
      s_vld    = vecs[i].sv;
      s_data   = {32'h0, vecs[i].sd0};
      m_ack    = vecs[i].ma;
      @(negedge clk);
      sample_model();
      check($sformatf("vec%0d s_ack", i), 64'(s_ack), 64'(vecs[i].e_sack));
      check($sformatf("vec%0d m_vld", i), 64'(m_vld), 64'(vecs[i].e_mvld));
      check($sformatf("vec%0d occ0", i), 64'(occupancy[2:0]), 64'(vecs[i].e_occ0));
      check($sformatf("vec%0d occ1", i), 64'(occupancy[5:3]), 64'(vecs[i].e_occ1));
      if (vecs[i].e_mvld[0])
        check($sformatf("vec%0d m_data0", i), 64'(m_data[31:0]), 64'(vecs[i].e_d0));
      advance();
    end

    // ---- ch1 streaming: 10 words, one-cycle latency, pointers wrap ----
    idle_inputs();
    for (int i = 0; i < 11; i++) begin
      s_vld  = (i < 10) ? 2'b10 : 2'b00;
      m_ack  = 2'b10;
      s_data = {PB'(32'h10 + i), 32'h0};
      @(negedge clk);
      sample_model();
      if (i == 0) begin
        check("stream m_vld1 first", 64'(m_vld[1]), 64'd0);
      end else begin
        check($sformatf("stream occ1 #%0d", i), 64'(occupancy[5:3]), 64'd1);
        check($sformatf("stream data1 #%0d", i), 64'(m_data[63:32]), 64'(32'h10 + i - 1));
      end
      advance();
    end
    idle_inputs();
    cycle();

    // ---- ap_start low: pushes land, output held back ----
    ap_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_vld  = 2'b01;
      s_data = {32'h0, PB'(32'hB0 + i)};
      cycle();
    end
    s_vld = '0;
    @(negedge clk);
    sample_model();
    check("apoff m_vld0", 64'(m_vld[0]), 64'd0);
    check("apoff occ0", 64'(occupancy[2:0]), 64'd3);
    advance();
    ap_start = 1'b1;
    @(negedge clk);
    sample_model();
    check("apon m_vld0", 64'(m_vld[0]), 64'd1);
    check("apon m_data0", 64'(m_data[31:0]), 64'hB0);
    advance();

    // ---- flush ch0 while pushing; ch1 untouched ----
    for (int i = 0; i < 2; i++) begin
      s_vld  = 2'b10;
      s_data = {PB'(32'hC0 + i), 32'h0};
      cycle();
    end
    s_vld  = 2'b01;
    s_data = {32'h0, 32'hDD};
    flush  = 2'b01;
    @(negedge clk);
    sample_model();
    check("flush s_ack0", 64'(s_ack[0]), 64'd0);
    check("flush m_vld0", 64'(m_vld[0]), 64'd0);
    advance();
    idle_inputs();
    @(negedge clk);
    sample_model();
    check("postflush occ0", 64'(occupancy[2:0]), 64'd0);
    check("postflush m_vld0", 64'(m_vld[0]), 64'd0);
    check("postflush occ1", 64'(occupancy[5:3]), 64'd2);
    check("postflush m_data1", 64'(m_data[63:32]), 64'hC0);
    advance();

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      ap_start = ($urandom_range(0, 9) != 0);
      flush    = {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)};
      s_vld    = 2'($urandom_range(0, 3));
      m_ack    = 2'($urandom_range(0, 3));
      s_data   = {$urandom(), $urandom()};
      cycle();
    end

`ifdef LEAF_STREAM_STATS_EN
    // ---- statistics: 5 pops, flush, 2 pops -> 7; reset clears ----
    idle_inputs();
    reset = 1'b1;
    cycle();
    idle_inputs();
    s_vld = 2'b01; m_ack = 2'b01;
    for (int i = 0; i < 6; i++) begin
      s_data = {32'h0, PB'(32'hE0 + i)};
      cycle();
    end
    idle_inputs();
    flush = 2'b01;
    cycle();
    idle_inputs();
    s_vld = 2'b01; m_ack = 2'b01;
    for (int i = 0; i < 3; i++) begin
      s_data = {32'h0, PB'(32'hF0 + i)};
      cycle();
    end
    idle_inputs();
    check("stat ch0 seven", 64'(stat_words[31:0]), 64'd7);
    reset = 1'b1;
    cycle();
    idle_inputs();
    check("stat ch0 reset", 64'(stat_words[31:0]), 64'd0);
    cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaf_stream_buffer.md
Name: leaf_stream_buffer

Overview:
- Parametrised multi-channel elastic buffer between a leaf_interface user-side bus and a user kernel's AXI-stream ports.
- Generalises the fixed 2-in/2-out, 32-bit, unbuffered wiring to NUM_CH channels of PAYLOAD_BITS width. Each channel has its own FIFO of 2**DEPTH_BITS entries, an independent flush, and output gating by ap_start.
- One instance is placed per direction: interface-to-kernel and kernel-to-interface.

Parameters:
- PAYLOAD_BITS, 32: data width per channel.
- NUM_CH, 2: number of independent channels; channel k occupies bits [k*PAYLOAD_BITS +: PAYLOAD_BITS].
- DEPTH_BITS, 2: log2 of per-channel FIFO depth; depth = 2**DEPTH_BITS, minimum DEPTH_BITS = 1.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  gates m_vld; when low, no channel presents data.
- flush  in  NUM_CH  per-channel synchronous clear of FIFO contents.
- s_data  in  NUM_CH*PAYLOAD_BITS  upstream data.
- s_vld  in  NUM_CH  upstream valid.
- s_ack  out  NUM_CH  ready to upstream.
- m_data  out  NUM_CH*PAYLOAD_BITS  downstream data (FIFO head).
- m_vld  out  NUM_CH  downstream valid.
- m_ack  in  NUM_CH  ready from downstream.
- occupancy  out  NUM_CH*(DEPTH_BITS+1)  per-channel entry count.

Behaviour:
- Channels are fully independent. Each channel has a write pointer and a read pointer (DEPTH_BITS wide, wrapping modulo depth), a count (DEPTH_BITS+1 wide) and a register array.
- Push occurs when s_vld[k] && s_ack[k]. Pop occurs when m_vld[k] && m_ack[k].
- s_ack[k] = !reset && !flush[k] && (count[k] != depth).
  - Depends only on local state; no combinational path from m_ack to s_ack.
- m_vld[k] = ap_start && !flush[k] && (count[k] != 0).
- m_data[k] = array[k][rd_ptr[k]]. Combinational read of registered storage; stable while m_vld is high and m_ack is low.
- Latency: a word pushed in cycle N is visible on m_vld/m_data in cycle N+1. There is no same-cycle pass-through.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged, both pointers advance.
- Full (count = depth): s_ack low, so no push. A pop in that cycle frees one entry, and s_ack rises the next cycle.
- Empty (count = 0): m_vld low. A push in that cycle gives m_vld = 1 the next cycle (if ap_start).
- Wrap-around: pointers roll from depth-1 to 0 with no bubble. Ordering is strictly FIFO per channel.
- Flush: when flush[k] is high, that channel's wr_ptr, rd_ptr and count are cleared at the clock edge. Flush takes priority over a simultaneous push or pop; both are suppressed because s_ack and m_vld are low. Other channels are unaffected.
- ap_start low:
  - Pushes continue until full; pops are blocked.
  - Stored data is retained.
  - Rising ap_start presents the head in the same cycle.
- Reset (including mid-transfer): all pointers and counts go to 0. Contents are discarded and need no reset.
  - While reset is high: s_ack = 0 and m_vld = 0.
  - After release: occupancy = 0, s_ack = all ones, m_vld = 0.
- occupancy[k] = count[k]. Reset value is 0.

Optional Feature:
- Macro: LEAF_STREAM_STATS_EN.
- When defined:
  - Adds output port stat_words, NUM_CH*32 bits: a per-channel 32-bit count of pops.
  - Increments by 1 on each pop and wraps from 0xFFFFFFFF to 0.
  - Cleared by reset only; not cleared by flush.
- When undefined:
  - The port and counters do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset then idle (NUM_CH=2, DEPTH_BITS=2) -> occupancy = 0/0, s_ack = 2'b11, m_vld = 2'b00. With reset high, s_ack = 2'b00.
- Ch0 push 0xA0..0xA3 with m_ack = 0 -> occupancy0 = 4, s_ack[0] = 0 after the 4th push. Then m_ack = 1 -> pops A0, A1, A2, A3 in order on consecutive cycles, and s_ack[0] = 1 the cycle after the first pop.
- Ch1 continuous push and pop for 10 words 0x10..0x19, s_vld = m_ack = 1 -> output 0x10..0x19 in order, 1-cycle latency, occupancy1 steady at 1, pointers wrap twice.
- ap_start = 0, push 3 words on ch0 -> m_vld[0] = 0, occupancy0 = 3. Raise ap_start -> m_vld[0] = 1 the same cycle with the first word.
- Ch0 holding 3 words, flush[0] pulsed together with s_vld[0] = 1 -> next cycle occupancy0 = 0 and m_vld[0] = 0. Ch1 contents and occupancy are unchanged.
- With LEAF_STREAM_STATS_EN defined: 5 pops on ch0, then flush, then 2 pops -> stat_words[ch0] = 7. Reset -> 0.
